// File: rtl/scan_pkg.sv
// Shared types and helpers for the decoder scan sequencer.
// Holds the FSM state encoding, channel-count constants and the
// next-enabled-channel search used for both in-pass stepping and pass restart.
package scan_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    GAP  = 2'd2
  } state_e;

  // Result of a channel search: wrap=1 means no enabled channel lies above
  // the current one, and ch then holds the lowest enabled channel instead.
  typedef struct packed {
    logic             wrap;
    logic [SEL_W-1:0] ch;
  } next_ch_t;

  // Searching above channel NUM_CH-1 always wraps, so the same function
  // also yields the lowest enabled channel of a freshly latched mask.
  function automatic next_ch_t next_enabled(input logic [NUM_CH-1:0] mask,
                                            input logic [SEL_W-1:0]  cur);
    next_ch_t r;
    r.wrap = 1'b1;
    r.ch   = '0;
    // Walk downward so the lowest enabled channel is the survivor.
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i]) r.ch = SEL_W'(i);
    end
    // First enabled channel strictly above cur overrides the wrap candidate.
    for (int i = 0; i < NUM_CH; i++) begin
      if (r.wrap && mask[i] && (i > int'(cur))) begin
        r.ch   = SEL_W'(i);
        r.wrap = 1'b0;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/scan_sequencer_dwell_timer.sv
// Loadable down-counter that times one channel's dwell period.
// Ports: clk, rst (async active-high), load + value (count to load),
//        expire (high in the last cycle of the loaded period).
module dwell_timer #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [DWELL_W-1:0] value,
  output logic               expire
);

  logic [DWELL_W-1:0] cnt_q;
  logic [DWELL_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      // A zero dwell still gives the channel one full cycle.
      cnt_d = (value == '0) ? DWELL_W'(1) : value;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - DWELL_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Loaded value N gives N cycles with cnt_q = N..1; expire marks the last.
  assign expire = (cnt_q == DWELL_W'(1));

endmodule

// File: rtl/scan_sequencer.sv
// Scans a 2-to-4 decoder through the enabled channels, each held for a
// programmable dwell, with a one-cycle E-low gap between channels.
// Ports: clk, rst (async active-high); start/stop/single control;
//        chan_en mask and dwell config; E/I0/I1 decoder drive;
//        busy (SCAN or GAP) and pass_done (one-cycle end-of-pass pulse).
module scan_sequencer
  import scan_pkg::*;
#(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               single,
  input  logic [NUM_CH-1:0]  chan_en,
  input  logic [DWELL_W-1:0] dwell,
  output logic               E,
  output logic               I0,
  output logic               I1,
  output logic               busy,
  output logic               pass_done
);

  state_e             state_q,  state_d;
  logic [NUM_CH-1:0]  mask_q,   mask_d;
  logic [DWELL_W-1:0] dwell_q,  dwell_d;
  logic               single_q, single_d;
  logic [SEL_W-1:0]   sel_q,    sel_d;
  logic               e_q,      e_d;
  logic               busy_q,   busy_d;
  logic               pd_q,     pd_d;

  logic               tmr_load;
  logic [DWELL_W-1:0] tmr_val;
  logic               tmr_expire;

  next_ch_t           nxt_cur;  // next channel within the latched mask
  next_ch_t           nxt_new;  // lowest channel of the live chan_en input

  assign nxt_cur = next_enabled(mask_q, sel_q);
  assign nxt_new = next_enabled(chan_en, SEL_W'(NUM_CH - 1));

  dwell_timer #(
    .DWELL_W (DWELL_W)
  ) u_dwell_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (tmr_load),
    .value  (tmr_val),
    .expire (tmr_expire)
  );

  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    dwell_d  = dwell_q;
    single_d = single_q;
    sel_d    = sel_q;
    e_d      = 1'b0;
    pd_d     = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = dwell_q;

    if (stop) begin
      // Abort overrides everything, including a coincident start.
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start && (chan_en != '0)) begin
            mask_d   = chan_en;
            dwell_d  = dwell;
            single_d = single;
            sel_d    = nxt_new.ch;
            tmr_load = 1'b1;
            tmr_val  = dwell;
            e_d      = 1'b1;
            state_d  = SCAN;
          end
        end

        SCAN: begin
          e_d = 1'b1;
          if (tmr_expire) begin
            e_d     = 1'b0;
            state_d = GAP;
            // The pulse lands in the GAP cycle that closes the pass.
            pd_d    = nxt_cur.wrap;
          end
        end

        GAP: begin
          if (!nxt_cur.wrap) begin
            sel_d    = nxt_cur.ch;
            tmr_load = 1'b1;
            e_d      = 1'b1;
            state_d  = SCAN;
          end else if (single_q) begin
            state_d = IDLE;
          end else if (chan_en != '0) begin
            // Pass boundary is the only point where new config takes effect.
            mask_d   = chan_en;
            dwell_d  = dwell;
            sel_d    = nxt_new.ch;
            tmr_load = 1'b1;
            tmr_val  = dwell;
            e_d      = 1'b1;
            state_d  = SCAN;
          end else begin
            state_d = IDLE;
          end
        end

        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      mask_q   <= '0;
      dwell_q  <= '0;
      single_q <= 1'b0;
      sel_q    <= '0;
      e_q      <= 1'b0;
      busy_q   <= 1'b0;
      pd_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      dwell_q  <= dwell_d;
      single_q <= single_d;
      sel_q    <= sel_d;
      e_q      <= e_d;
      busy_q   <= busy_d;
      pd_q     <= pd_d;
    end
  end

  assign E         = e_q;
  assign I0        = sel_q[0];
  assign I1        = sel_q[1];
  assign busy      = busy_q;
  assign pass_done = pd_q;

endmodule
